// File: rtl/regwrite_trace_fifo_pkg.sv
// trace_pkg: shared constants for the register-write trace FIFO.
// Holds the FSM state encoding, field widths and the bit offsets used to
// pack/unpack one trace entry {cycle, reg, data} (data in the low bits).
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_FROZEN = 2'b10
  } state_e;

  localparam int REG_W   = 5;
  localparam int DATA_W  = 32;
  localparam int DROP_W  = 16;

  // Default timestamp width; the top level may override CYCLE_W.
  localparam int CYCLE_W_DEF = 10;
  localparam int ENTRY_W     = CYCLE_W_DEF + REG_W + DATA_W;

  // Entry layout: [CYC_LSB +: CYCLE_W][REG_LSB +: REG_W][DATA_LSB +: DATA_W]
  localparam int DATA_LSB = 0;
  localparam int REG_LSB  = DATA_LSB + DATA_W;
  localparam int CYC_LSB  = REG_LSB + REG_W;

  function automatic int entry_w(input int cycle_w);
    return cycle_w + REG_W + DATA_W;
  endfunction

endpackage

// File: rtl/regwrite_trace_fifo_fifo.sv
// sync_fifo_fwft: first-word-fall-through synchronous FIFO.
// The head entry is visible on dout whenever empty is low; a push lands in
// storage on the edge and is visible after it (1-cycle latency).
// Ports:
//   clock, reset      : system clock, synchronous active-high reset
//   push / din        : write request and data (ignored when full unless pop)
//   pop               : consume head (ignored when empty)
//   dout              : head entry (undefined content when empty)
//   full, empty, count: occupancy status, count in 0..DEPTH
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // A push into a full FIFO is legal when the head leaves on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign dout = mem[rd_ptr];

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: nothing reads it while empty.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/regwrite_trace_fifo.sv
// regwrite_trace_fifo: taps the regfile write port, timestamps every write to
// a nonzero register while running, and buffers it for a valid/ready drain.
// Optional feature macro: TRACE_DROP_CNT_EN adds a saturating drop_cnt output.
// Ports:
//   clock, reset                 : system clock, synchronous active-high reset
//   start, stop                  : run control pulses (IDLE/FROZEN->RUN, RUN->FROZEN)
//   ctrl_writeEnable/_writeReg,
//   data_writeReg                : regfile write port being observed
//   out_valid/out_ready          : drain handshake; out_cycle/reg/data = head entry
//   count                        : FIFO occupancy 0..DEPTH
//   overflow                     : sticky, a capture was dropped
//   state                        : 00 IDLE, 01 RUN, 10 FROZEN
//   drop_cnt (macro only)        : number of dropped captures, saturating
module regwrite_trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int CYCLE_W = 10
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    ctrl_writeEnable,
  input  logic [4:0]              ctrl_writeReg,
  input  logic [31:0]             data_writeReg,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CYCLE_W-1:0]      out_cycle,
  output logic [4:0]              out_reg,
  output logic [31:0]             out_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic [1:0]              state
`ifdef TRACE_DROP_CNT_EN
  ,
  output logic [DROP_W-1:0]       drop_cnt
`endif
);

  localparam int EW = entry_w(CYCLE_W);

  state_e             st, st_nxt;
  logic [CYCLE_W-1:0] cyc;
  logic               capture, pop, push, drop, full, empty;
  logic [EW-1:0]      entry, head;

  assign state = st;

  // Stop wins while running, start wins otherwise.
  always_comb begin
    st_nxt = st;
    case (st)
      ST_IDLE:   if (start) st_nxt = ST_RUN;
      ST_RUN:    if (stop)  st_nxt = ST_FROZEN;
      ST_FROZEN: if (start) st_nxt = ST_RUN;
      default:   st_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) st <= ST_IDLE;
    else       st <= st_nxt;
  end

  // Counter runs on every RUN edge (including the one that stops it) and is
  // only cleared on entry from IDLE, so FROZEN->RUN resumes where it left off.
  always_ff @(posedge clock) begin
    if (reset)                     cyc <= '0;
    else if (st == ST_IDLE && start) cyc <= '0;
    else if (st == ST_RUN)         cyc <= cyc + CYCLE_W'(1);
  end

  // Capture uses the registered state, so the IDLE->RUN edge never captures.
  assign capture = (st == ST_RUN) && ctrl_writeEnable && (ctrl_writeReg != '0);
  assign pop     = out_valid && out_ready;
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop;
  assign entry   = {cyc, ctrl_writeReg, data_writeReg};

  sync_fifo_fwft #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (entry),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign out_valid = !empty;
  assign out_cycle = empty ? '0 : head[CYC_LSB  +: CYCLE_W];
  assign out_reg   = empty ? '0 : head[REG_LSB  +: REG_W];
  assign out_data  = empty ? '0 : head[DATA_LSB +: DATA_W];

`ifdef TRACE_DROP_CNT_EN
  always_ff @(posedge clock) begin
    if (reset)                                 drop_cnt <= '0;
    else if (drop && drop_cnt != {DROP_W{1'b1}}) drop_cnt <= drop_cnt + DROP_W'(1);
  end
  assign overflow = (drop_cnt != '0);
`else
  always_ff @(posedge clock) begin
    if (reset)     overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_regwrite_trace_fifo.sv
// Scoreboard bench for regwrite_trace_fifo (DEPTH=16, CYCLE_W=10).
// Stimulus pushes hand-computed expected entries; a negedge monitor pops and
// compares whenever the DUT hands an entry over (out_valid && out_ready).
module tb_regwrite_trace_fifo;

  typedef struct packed {
    logic [9:0]  cyc;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset, start, stop, we, out_ready;
  logic [4:0]  wreg;
  logic [31:0] wdata;
  logic        out_valid, overflow;
  logic [9:0]  out_cycle;
  logic [4:0]  out_reg;
  logic [31:0] out_data;
  logic [4:0]  count;
  logic [1:0]  state;
`ifdef TRACE_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;

  always #5 clock = ~clock;

  regwrite_trace_fifo #(.DEPTH(16), .CYCLE_W(10)) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .stop             (stop),
    .ctrl_writeEnable (we),
    .ctrl_writeReg    (wreg),
    .data_writeReg    (wdata),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_cycle        (out_cycle),
    .out_reg          (out_reg),
    .out_data         (out_data),
    .count            (count),
    .overflow         (overflow),
    .state            (state)
`ifdef TRACE_DROP_CNT_EN
    ,
    .drop_cnt         (drop_cnt)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic exp_t mk(input int c, input int r, input logic [31:0] d);
    exp_t e;
    e.cyc  = c[9:0];
    e.rd   = r[4:0];
    e.data = d;
    return e;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic neg();
    @(negedge clock);
  endtask

  task automatic wr(input int r, input logic [31:0] d);
    we = 1'b1; wreg = r[4:0]; wdata = d;
  endtask

  task automatic wr_clr();
    we = 1'b0; wreg = '0; wdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; out_ready = 1'b0;
    wr_clr();
    tick();
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Monitor: every handshake must match the oldest expected entry.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL head_unexpected: got cyc=%0d reg=%0d data=0x%0h, expected no entry",
                 out_cycle, out_reg, out_data);
      end else begin
        mon_e = sb.pop_front();
        chk("head_cycle", 64'(out_cycle), 64'(mon_e.cyc));
        chk("head_reg",   64'(out_reg),   64'(mon_e.rd));
        chk("head_data",  64'(out_data),  64'(mon_e.data));
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; out_ready = 1'b0;
    we = 1'b0; wreg = '0; wdata = '0;
    tick(); tick();

    // Reset state
    do_reset();
    neg();
    chk("rst_state", 64'(state), 0);
    chk("rst_count", 64'(count), 0);
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_ovf",   64'(overflow), 0);
    chk("rst_fields", {22'd0, out_cycle, out_reg, out_data} , 0);

    // 1: two writes at RUN cycles 2 and 4
    out_ready = 1'b1;
    do_start();
    neg(); chk("t1_state_run", 64'(state), 1);
    tick(); tick();
    wr(3, 32'd7); sb.push_back(mk(2, 3, 32'd7));
    tick(); wr_clr();
    neg(); chk("t1_latency_count", 64'(count), 1);
    tick();
    wr(5, 32'hFFFF_FFFF); sb.push_back(mk(4, 5, 32'hFFFF_FFFF));
    tick(); wr_clr();
    repeat (3) tick();
    neg(); chk("t1_ovf", 64'(overflow), 0);
    chk("t1_count", 64'(count), 0);

    // 2: r0 writes, IDLE writes and the IDLE->RUN edge are not captured
    do_reset();
    wr(4, 32'd11); tick(); wr_clr();
    neg(); chk("t2_idle_count", 64'(count), 0);
    start = 1'b1; wr(6, 32'd66); tick(); start = 1'b0; wr_clr();
    neg(); chk("t2_startedge_count", 64'(count), 0);
    chk("t2_state", 64'(state), 1);
    wr(0, 32'd99); tick(); wr_clr();
    neg(); chk("t2_r0_count", 64'(count), 0);
    chk("t2_r0_valid", 64'(out_valid), 0);

    // 3: 17 captures into 16 entries; the 17th is dropped
    do_reset();
    do_start();
    for (int i = 0; i < 17; i++) begin
      wr(i + 1, 32'h100 + i);
      if (i < 16) sb.push_back(mk(i, i + 1, 32'h100 + i));
      tick();
    end
    wr_clr();
    neg(); chk("t3_count_full", 64'(count), 16);
    chk("t3_ovf", 64'(overflow), 1);
`ifdef TRACE_DROP_CNT_EN
    chk("t3_drop_cnt", 64'(drop_cnt), 1);
`endif
    tick();
    out_ready = 1'b1;
    repeat (20) tick();
    neg(); chk("t3_drained", 64'(count), 0);
    chk("t3_ovf_sticky", 64'(overflow), 1);

    // 4: full + pop + push on the same edge keeps 16 and drops nothing
    do_reset();
    do_start();
    for (int i = 0; i < 16; i++) begin
      wr(i + 1, 32'h200 + i);
      sb.push_back(mk(i, i + 1, 32'h200 + i));
      tick();
    end
    out_ready = 1'b1;
    wr(9, 32'hABCD); sb.push_back(mk(16, 9, 32'hABCD));
    tick();
    wr_clr(); out_ready = 1'b0;
    neg(); chk("t4_count", 64'(count), 16);
    chk("t4_ovf", 64'(overflow), 0);
    tick();
    out_ready = 1'b1;
    repeat (20) tick();
    neg(); chk("t4_drained", 64'(count), 0);

    // 5: stop/resume keeps the counter; simultaneous start+stop
    do_reset();
    out_ready = 1'b1;
    do_start();
    repeat (4) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    neg(); chk("t5_frozen", 64'(state), 2);
    repeat (3) tick();
    neg(); chk("t5_frozen_hold", 64'(state), 2);
    do_start();
    neg(); chk("t5_resumed", 64'(state), 1);
    wr(2, 32'd42); sb.push_back(mk(5, 2, 32'd42));
    tick(); wr_clr();
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    neg(); chk("t5_both_run", 64'(state), 2);
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    neg(); chk("t5_both_frozen", 64'(state), 1);
    wr(7, 32'd77); sb.push_back(mk(7, 7, 32'd77));
    tick(); wr_clr();
    repeat (3) tick();

    // 6: counter wrap, then reset in the middle of a drain
    do_reset();
    out_ready = 1'b1;
    do_start();
    repeat (1025) tick();
    wr(1, 32'd1); sb.push_back(mk(1, 1, 32'd1));
    tick(); wr_clr();
    repeat (3) tick();
    do_reset();
    do_start();
    for (int i = 0; i < 3; i++) begin
      wr(10 + i, 32'h300 + i);
      sb.push_back(mk(i, 10 + i, 32'h300 + i));
      tick();
    end
    wr_clr();
    out_ready = 1'b1;
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    sb.delete();
    neg(); chk("t6_rst_valid", 64'(out_valid), 0);
    chk("t6_rst_count", 64'(count), 0);
    chk("t6_rst_state", 64'(state), 0);
    tick();

    chk("sb_empty", 64'(sb.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
